// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        SEND,
        WAIT
    } arb_state_t;

    localparam byte_t ASCII_LF = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start_i, wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    int k;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(start_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid_o && req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-atomic round-robin arbiter sharing one UART TX channel among N byte-stream requesters,
// with a stall watchdog that reclaims the channel from a requester that stops mid-line.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int    N       = 2,
    parameter byte_t TERM    = ASCII_LF,
    parameter int    TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*8-1:0] req_data,
    output logic [N-1:0]   req_ready,
    input  logic           output_busy,
    output logic           output_en,
    output logic [7:0]     output_data,
    output logic [N-1:0]   grant,
    output logic           timeout_flag
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          en_q, en_d;
    byte_t         data_q, data_d;
    logic          term_q, term_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          tflag_q, tflag_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          cur_valid;
    byte_t         cur_byte;
    logic          accept;
    logic [IW-1:0] g_inc;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i   (req_valid),
        .start_i (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Valid/ready: a byte transfers on a cycle where req_valid[i] and req_ready[i] are both high;
    // the requester must hold valid and data stable until then. Only the owner ever sees ready.
    assign cur_valid = req_valid[g_q];
    assign cur_byte  = req_data[{g_q, 3'b000} +: 8];
    assign accept    = (state_q == OWN) && cur_valid && !output_busy;
    assign g_inc     = (g_q == IW'(N - 1)) ? '0 : g_q + IW'(1);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[g_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        en_d    = 1'b0;
        data_d  = data_q;
        term_d  = term_q;
        stall_d = stall_q;
        tflag_d = tflag_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    g_d               = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    stall_d           = '0;
                    state_d           = OWN;
                end
            end
            OWN: begin
                if (accept) begin
                    en_d    = 1'b1;
                    data_d  = cur_byte;
                    term_d  = (cur_byte == TERM);
                    stall_d = '0;
                    state_d = SEND;
                end else if (TIMEOUT != 0 && !cur_valid && !output_busy) begin
                    // Only cycles where the owner is silent and the UART is free count as stall.
                    stall_d = stall_q + SW'(1);
                    if (stall_d == SW'(TIMEOUT)) begin
                        tflag_d = 1'b1;
                        rr_d    = g_inc;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!output_busy) begin
                    if (term_q) begin
                        rr_d    = g_inc;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = OWN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
            term_q  <= 1'b0;
            stall_q <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            en_q    <= en_d;
            data_q  <= data_d;
            term_q  <= term_d;
            stall_q <= stall_d;
            tflag_q <= tflag_d;
        end
    end

    assign output_en    = en_q;
    assign output_data  = data_q;
    assign grant        = grant_q;
    assign timeout_flag = tflag_q;

endmodule
